prime_pair_finder: RTL and testbench

- Sequencer that drives one primality tester to find two distinct primes p and q for RSA key generation.
- Starts from a seed and walks odd candidates upward. Each candidate is issued to the tester and its verdict collected. The first prime found is latched as p, the next distinct prime as q.
- Sits between the keygen top-level and the primality tester. It is the only master of the tester's start and number inputs.

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/candidate_gen.sv | 42 ++++
 rtl/prime_pair_finder.sv | 249 ++++++++++++++++++++++++
 tb/tb_prime_pair_finder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA key-generation prime search.
package rsa_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Sequencer states of the prime pair finder
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    EVAL  = 3'd4,
    DONE  = 3'd5,
    FAIL  = 3'd6
  } state_e;

  // fail_code encodings
  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_ATTEMPTS = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/candidate_gen.sv
// Combinational candidate stepper: next odd candidate with wrap-to-3, plus a
// skip flag for the current candidate (equal to p while searching for q, or,
// when the filter is enabled, a multiple of 3, 5 or 7 other than those primes).
// The filter_en input is tied high by the top when SMALL_PRIME_FILTER_EN is defined.
module candidate_gen
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] cand,
  input  logic             p_found,
  input  logic [WIDTH-1:0] p_val,
  input  logic             filter_en,
  output logic [WIDTH-1:0] next_cand,
  output logic             skip
);

  logic [WIDTH:0] sum_ext;
  logic           small_div;
  logic           is_small_prime;

  assign sum_ext = {1'b0, cand} + (WIDTH + 1)'(2);

  // Step by two; an overflow or a wrapped value below 3 restarts at 3
  always_comb begin
    next_cand = sum_ext[WIDTH-1:0];
    if (sum_ext[WIDTH] || (sum_ext[WIDTH-1:0] < WIDTH'(3))) begin
      next_cand = WIDTH'(3);
    end
  end

  // Decide whether the current candidate is skipped instead of issued
  always_comb begin
    small_div      = ((cand % WIDTH'(3)) == '0) ||
                     ((cand % WIDTH'(5)) == '0) ||
                     ((cand % WIDTH'(7)) == '0);
    is_small_prime = (cand == WIDTH'(3)) || (cand == WIDTH'(5)) || (cand == WIDTH'(7));
    skip           = (p_found && (cand == p_val)) ||
                     (filter_en && small_div && !is_small_prime);
  end

endmodule

// File: rtl/prime_pair_finder.sv
// Prime pair finder: walks odd candidates from a seed, drives one primality
// tester, and latches the first two distinct primes as p and q.
// Optional build macro: SMALL_PRIME_FILTER_EN (skip multiples of 3, 5, 7
// without consulting the tester).
module prime_pair_finder
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned MAX_ATTEMPTS = 256,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [WIDTH-1:0]                    seed,
  output logic [WIDTH-1:0]                    pt_number,
  output logic                                pt_start,
  input  logic                                pt_is_prime,
  input  logic                                pt_done,
  output logic [WIDTH-1:0]                    p_out,
  output logic [WIDTH-1:0]                    q_out,
  output logic                                valid,
  output logic                                busy,
  output logic                                fail,
  output logic [1:0]                          fail_code,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   tries
);

  localparam int unsigned TRIES_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned WDOG_W  = $clog2(TIMEOUT + 1);
  localparam logic [TRIES_W-1:0] MAX_TRIES = TRIES_W'(MAX_ATTEMPTS);
  localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TIMEOUT - 1);

`ifdef SMALL_PRIME_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  state_e               state_q,     state_d;
  logic [WIDTH-1:0]     seed_q,      seed_d;
  logic [WIDTH-1:0]     cand_q,      cand_d;
  logic [WIDTH-1:0]     p_q,         p_d;
  logic [WIDTH-1:0]     q_q,         q_d;
  logic                 p_found_q,   p_found_d;
  logic                 verdict_q,   verdict_d;
  logic [TRIES_W-1:0]   tries_q,     tries_d;
  logic [WDOG_W-1:0]    wdog_q,      wdog_d;
  logic                 pt_start_q,  pt_start_d;
  logic                 valid_q,     valid_d;
  logic                 fail_q,      fail_d;
  logic [1:0]           fail_code_q, fail_code_d;
  logic                 busy_q,      busy_d;
`ifdef SMALL_PRIME_FILTER_EN
  logic [WIDTH-1:0]     skip_cnt_q,  skip_cnt_d;
`endif

  logic [WIDTH-1:0]     seed_odd;
  logic [WIDTH-1:0]     init_cand;
  logic [WIDTH-1:0]     next_cand;
  logic                 skip;

  // Candidate stepping and skip decision
  candidate_gen #(
    .WIDTH (WIDTH)
  ) u_candidate_gen (
    .cand      (cand_q),
    .p_found   (p_found_q),
    .p_val     (p_q),
    .filter_en (FILTER_EN),
    .next_cand (next_cand),
    .skip      (skip)
  );

  // First candidate: force odd, and never start below 3
  always_comb begin
    seed_odd  = seed_q | WIDTH'(1);
    init_cand = (seed_odd < WIDTH'(3)) ? WIDTH'(3) : seed_odd;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    cand_d      = cand_q;
    p_d         = p_q;
    q_d         = q_q;
    p_found_d   = p_found_q;
    verdict_d   = verdict_q;
    tries_d     = tries_q;
    wdog_d      = wdog_q;
    pt_start_d  = 1'b0;
    valid_d     = valid_q;
    fail_d      = fail_q;
    fail_code_d = fail_code_q;
`ifdef SMALL_PRIME_FILTER_EN
    skip_cnt_d  = skip_cnt_q;
`endif

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          seed_d      = seed;
          valid_d     = 1'b0;
          fail_d      = 1'b0;
          fail_code_d = FC_NONE;
          tries_d     = '0;
          p_d         = '0;
          q_d         = '0;
          p_found_d   = 1'b0;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        cand_d  = init_cand;
`ifdef SMALL_PRIME_FILTER_EN
        skip_cnt_d = '0;
`endif
        state_d = ISSUE;
      end

      ISSUE: begin
        if (skip) begin
          // Skipped candidates take one cycle, no pulse, no try
          cand_d = next_cand;
`ifdef SMALL_PRIME_FILTER_EN
          if (skip_cnt_q == '1) begin
            fail_d      = 1'b1;
            fail_code_d = FC_ATTEMPTS;
            p_d         = '0;
            q_d         = '0;
            state_d     = FAIL;
          end else begin
            skip_cnt_d = skip_cnt_q + WIDTH'(1);
          end
`endif
        end else if (!pt_done) begin
          pt_start_d = 1'b1;
          if (tries_q != MAX_TRIES) begin
            tries_d = tries_q + TRIES_W'(1);
          end
          wdog_d  = '0;
`ifdef SMALL_PRIME_FILTER_EN
          skip_cnt_d = '0;
`endif
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A verdict on the expiry cycle still wins over the timeout
        if (pt_done) begin
          verdict_d = pt_is_prime;
          state_d   = EVAL;
        end else if (wdog_q == WDOG_LAST) begin
          fail_d      = 1'b1;
          fail_code_d = FC_TIMEOUT;
          p_d         = '0;
          q_d         = '0;
          state_d     = FAIL;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end

      EVAL: begin
        if (verdict_q && p_found_q) begin
          q_d     = cand_q;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          if (verdict_q) begin
            p_d       = cand_q;
            p_found_d = 1'b1;
          end
          cand_d = next_cand;
          if (tries_q == MAX_TRIES) begin
            fail_d      = 1'b1;
            fail_code_d = FC_ATTEMPTS;
            p_d         = '0;
            q_d         = '0;
            state_d     = FAIL;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = !(state_d inside {IDLE, DONE, FAIL});
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seed_q      <= '0;
      cand_q      <= '0;
      p_q         <= '0;
      q_q         <= '0;
      p_found_q   <= 1'b0;
      verdict_q   <= 1'b0;
      tries_q     <= '0;
      wdog_q      <= '0;
      pt_start_q  <= 1'b0;
      valid_q     <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= FC_NONE;
      busy_q      <= 1'b0;
`ifdef SMALL_PRIME_FILTER_EN
      skip_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      cand_q      <= cand_d;
      p_q         <= p_d;
      q_q         <= q_d;
      p_found_q   <= p_found_d;
      verdict_q   <= verdict_d;
      tries_q     <= tries_d;
      wdog_q      <= wdog_d;
      pt_start_q  <= pt_start_d;
      valid_q     <= valid_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
      busy_q      <= busy_d;
`ifdef SMALL_PRIME_FILTER_EN
      skip_cnt_q  <= skip_cnt_d;
`endif
    end
  end

  assign pt_number = cand_q;
  assign pt_start  = pt_start_q;
  assign p_out     = p_q;
  assign q_out     = q_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_prime_pair_finder.sv
// Directed bench for prime_pair_finder with a behavioural 10-cycle tester.
// Expected values adapt when SMALL_PRIME_FILTER_EN is defined.
module tb_prime_pair_finder;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned MAX_ATT = 4;
  localparam int unsigned TMO     = 4096;
  localparam int unsigned TW      = $clog2(MAX_ATT + 1);

`ifdef SMALL_PRIME_FILTER_EN
  localparam int unsigned   T14   = 2;
  localparam logic [31:0]   F14   = 32'd17;
  localparam int unsigned   TWRAP = 2;
  localparam logic [31:0]   FWRAP = 32'd3;
`else
  localparam int unsigned   T14   = 3;
  localparam logic [31:0]   F14   = 32'd15;
  localparam int unsigned   TWRAP = 3;
  localparam logic [31:0]   FWRAP = 32'hFFFF_FFFF;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] pt_number;
  logic             pt_start;
  logic             pt_is_prime;
  logic             pt_done;
  logic [WIDTH-1:0] p_out;
  logic [WIDTH-1:0] q_out;
  logic             valid;
  logic             busy;
  logic             fail;
  logic [1:0]       fail_code;
  logic [TW-1:0]    tries;

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic             hang = 1'b0;
  int               cnt;
  logic [31:0]      issued[$];
  int unsigned      dbl_pulse = 0;
  logic             prev_start = 1'b0;

  prime_pair_finder #(
    .WIDTH        (WIDTH),
    .MAX_ATTEMPTS (MAX_ATT),
    .TIMEOUT      (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .seed        (seed),
    .pt_number   (pt_number),
    .pt_start    (pt_start),
    .pt_is_prime (pt_is_prime),
    .pt_done     (pt_done),
    .p_out       (p_out),
    .q_out       (q_out),
    .valid       (valid),
    .busy        (busy),
    .fail        (fail),
    .fail_code   (fail_code),
    .tries       (tries)
  );

  always #5 clock = ~clock;

  function automatic logic is_prime_f(input logic [31:0] n);
    if (n < 32'd2) return 1'b0;
    if (n < 32'd4) return 1'b1;
    if (n[0] == 1'b0) return 1'b0;
    for (longint unsigned d = 3; d * d <= longint'(n); d += 2) begin
      if ((longint'(n) % d) == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Behavioural tester: verdict 10 cycles after the start pulse, one-cycle done
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= 0;
      pt_done     <= 1'b0;
      pt_is_prime <= 1'b0;
    end else if (pt_start) begin
      cnt     <= 10;
      pt_done <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && !hang) begin
        pt_done     <= 1'b1;
        pt_is_prime <= is_prime_f(pt_number);
      end
    end else begin
      pt_done <= 1'b0;
    end
  end

  // Record issued candidates and any pulse longer than one cycle
  always @(negedge clock) begin
    if (pt_start) issued.push_back(pt_number);
    if (pt_start && prev_start) dbl_pulse++;
    prev_start = pt_start;
  end

  task automatic pulse_start(input logic [31:0] s);
    @(negedge clock);
    seed  = s;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pulse(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pt_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; seed = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({valid, busy, fail, pt_start} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {valid, busy, fail, pt_start});
    else passed++;
    checks++;
    if ({pt_number, p_out, q_out} !== 96'd0)
      $display("FAIL reset_data: pt_number=%0h p=%0h q=%0h expected 0", pt_number, p_out, q_out);
    else passed++;
    checks++;
    if ({tries, fail_code} !== '0)
      $display("FAIL reset_counts: tries=%0d fail_code=%0d expected 0", tries, fail_code);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    issued.delete();
    pulse_start(32'd14);
    wait_idle(ok);
    checks++; if (ok !== 1'b1) $display("FAIL basic_done: busy stuck, got 0 expected 1"); else passed++;
    checks++; if (p_out !== 32'd17) $display("FAIL basic_p: got %0d expected 17", p_out); else passed++;
    checks++; if (q_out !== 32'd19) $display("FAIL basic_q: got %0d expected 19", q_out); else passed++;
    checks++; if ({valid, fail} !== 2'b10) $display("FAIL basic_flags: valid,fail got %b expected 10", {valid, fail}); else passed++;
    checks++; if (tries !== TW'(T14)) $display("FAIL basic_tries: got %0d expected %0d", tries, T14); else passed++;
    checks++; if (issued.size() !== int'(T14)) $display("FAIL basic_pulses: got %0d expected %0d", issued.size(), T14); else passed++;
    checks++; if (issued.size() == 0 || issued[0] !== F14) $display("FAIL basic_first: got %0d expected %0d", issued.size() == 0 ? 0 : issued[0], F14); else passed++;
  endtask

  task automatic test_attempt_limit();
    bit ok;
    issued.delete();
    pulse_start(32'd90);
    wait_idle(ok);
    checks++; if (ok !== 1'b1) $display("FAIL limit_done: busy stuck, got 0 expected 1"); else passed++;
`ifdef SMALL_PRIME_FILTER_EN
    checks++; if ({valid, fail} !== 2'b10) $display("FAIL limit_flags: valid,fail got %b expected 10", {valid, fail}); else passed++;
    checks++; if (p_out !== 32'd97 || q_out !== 32'd101) $display("FAIL limit_pq: got %0d,%0d expected 97,101", p_out, q_out); else passed++;
    checks++; if (tries !== TW'(2)) $display("FAIL limit_tries: got %0d expected 2", tries); else passed++;
`else
    checks++; if ({valid, fail} !== 2'b01) $display("FAIL limit_flags: valid,fail got %b expected 01", {valid, fail}); else passed++;
    checks++; if (fail_code !== 2'd1) $display("FAIL limit_code: got %0d expected 1", fail_code); else passed++;
    checks++; if (p_out !== 32'd0 || q_out !== 32'd0) $display("FAIL limit_pq: got %0d,%0d expected 0,0", p_out, q_out); else passed++;
    checks++; if (tries !== TW'(4)) $display("FAIL limit_tries: got %0d expected 4", tries); else passed++;
    checks++; if (issued.size() != 4 || issued[3] !== 32'd97) $display("FAIL limit_last: count %0d expected 4 ending in 97", issued.size()); else passed++;
`endif
  endtask

  task automatic test_small_seed();
    bit ok;
    issued.delete();
    pulse_start(32'd2);
    wait_idle(ok);
    checks++; if (ok !== 1'b1) $display("FAIL small_done: busy stuck, got 0 expected 1"); else passed++;
    checks++; if (p_out !== 32'd3 || q_out !== 32'd5) $display("FAIL small_pq: got %0d,%0d expected 3,5", p_out, q_out); else passed++;
    checks++; if ({valid, fail, fail_code} !== 4'b1000) $display("FAIL small_flags: got %b expected 1000", {valid, fail, fail_code}); else passed++;
    checks++; if (tries !== TW'(2)) $display("FAIL small_tries: got %0d expected 2", tries); else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    issued.delete();
    pulse_start(32'hFFFF_FFFF);
    wait_idle(ok);
    checks++; if (ok !== 1'b1) $display("FAIL wrap_done: busy stuck, got 0 expected 1"); else passed++;
    checks++; if (p_out !== 32'd3 || q_out !== 32'd5) $display("FAIL wrap_pq: got %0d,%0d expected 3,5", p_out, q_out); else passed++;
    checks++; if (tries !== TW'(TWRAP)) $display("FAIL wrap_tries: got %0d expected %0d", tries, TWRAP); else passed++;
    checks++; if (issued.size() == 0 || issued[0] !== FWRAP) $display("FAIL wrap_first: got %0h expected %0h", issued.size() == 0 ? 0 : issued[0], FWRAP); else passed++;
  endtask

  task automatic test_start_while_busy();
    bit ok;
    pulse_start(32'd14);
    repeat (5) @(negedge clock);
    seed  = 32'd2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle(ok);
    checks++; if (ok !== 1'b1) $display("FAIL busy_start_done: busy stuck, got 0 expected 1"); else passed++;
    checks++; if (p_out !== 32'd17 || q_out !== 32'd19) $display("FAIL busy_start_pq: got %0d,%0d expected 17,19", p_out, q_out); else passed++;
  endtask

  task automatic test_timeout();
    bit seen;
    bit early;
    hang = 1'b1;
    pulse_start(32'd14);
    wait_pulse(seen);
    checks++; if (seen !== 1'b1) $display("FAIL tmo_pulse: pt_start got 0 expected 1"); else passed++;
    early = 1'b0;
    repeat (TMO - 1) begin
      @(negedge clock);
      if (fail || !busy) early = 1'b1;
    end
    checks++; if (early !== 1'b0) $display("FAIL tmo_early: ended before %0d cycles, got 1 expected 0", TMO); else passed++;
    @(negedge clock);
    checks++; if ({fail, busy, valid} !== 3'b100) $display("FAIL tmo_flags: fail,busy,valid got %b expected 100", {fail, busy, valid}); else passed++;
    checks++; if (fail_code !== 2'd2) $display("FAIL tmo_code: got %0d expected 2", fail_code); else passed++;
    hang = 1'b0;
  endtask

  task automatic test_reset_during_wait();
    bit seen;
    bit ok;
    pulse_start(32'd14);
    wait_pulse(seen);
    repeat (3) @(negedge clock);
    checks++; if ({seen, busy} !== 2'b11) $display("FAIL rst_wait_pre: seen,busy got %b expected 11", {seen, busy}); else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if ({pt_number, p_out, q_out, tries, fail_code, valid, busy, fail, pt_start} !== '0)
      $display("FAIL rst_wait_zero: pt_number=%0h tries=%0d busy=%b expected all 0", pt_number, tries, busy);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    issued.delete();
    repeat (20) @(negedge clock);
    checks++; if (issued.size() !== 0) $display("FAIL rst_wait_quiet: pulses got %0d expected 0", issued.size()); else passed++;
    pulse_start(32'd14);
    wait_idle(ok);
    checks++; if (ok !== 1'b1) $display("FAIL rst_wait_done: busy stuck, got 0 expected 1"); else passed++;
    checks++; if (p_out !== 32'd17 || q_out !== 32'd19 || valid !== 1'b1) $display("FAIL rst_wait_pq: got %0d,%0d valid %b expected 17,19,1", p_out, q_out, valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_attempt_limit();
    test_small_seed();
    test_wrap();
    test_start_while_busy();
    test_timeout();
    test_reset_during_wait();
    checks++; if (dbl_pulse !== 0) $display("FAIL pulse_width: long pulses got %0d expected 0", dbl_pulse); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
